dma_irq_coalescer: RTL

//  Downstream of the DMA core wrapper: consumes the per-transfer completion pulse and raises one coalesced

---
 rtl/dma_irq_coalescer_pkg.sv | 6 +
 rtl/dma_irq_coalescer_sat_counter.sv | 30 +++
 rtl/dma_irq_coalescer.sv | 64 ++++++
 3 files changed

// File: rtl/dma_irq_coalescer_pkg.sv
// idma_irq_pkg: shared state encoding and default widths for the DMA interrupt coalescer.
package idma_irq_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} irq_state_e;
    localparam int unsigned DefCntWidth   = 8;
    localparam int unsigned DefTimerWidth = 16;
endpackage

// File: rtl/dma_irq_coalescer_sat_counter.sv
// dma_irq_sat_counter: saturating up-counter with clear and sticky overflow.
// Clear and increment together restart the count at 1.
module dma_irq_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [Width-1:0] o_val,
    output logic             o_ovf
);
    logic [Width-1:0] r_val;
    logic             r_ovf;
    logic             w_sat;
    logic [Width-1:0] w_nxt;
    assign w_sat = &r_val;
    assign w_nxt = i_clr ? Width'(i_inc) : (i_inc && !w_sat) ? r_val + Width'(1) : r_val;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_val <= w_nxt;
            r_ovf <= !i_clr && (r_ovf || (i_inc && w_sat));
        end
    end
    assign o_val = r_val;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/dma_irq_coalescer.sv
// dma_irq_coalescer: merges per-transfer completion pulses into one level interrupt,
// fired on a completion threshold or a timeout from the first unacknowledged completion.
module dma_irq_coalescer
    import idma_irq_pkg::*;
#(
    parameter int unsigned CntWidth   = DefCntWidth,
    parameter int unsigned TimerWidth = DefTimerWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  done_i,
    input  logic                  ack_i,
    input  logic [CntWidth-1:0]   threshold_i,
    input  logic [TimerWidth-1:0] timeout_i,
    output logic                  irq_o,
    output logic [CntWidth-1:0]   pending_o,
    output logic                  overflow_o
);
    irq_state_e            r_state;
    logic [CntWidth-1:0]   w_cnt;
    logic [CntWidth-1:0]   w_cnt_nxt;
    logic [CntWidth-1:0]   w_eff_thr;
    logic [TimerWidth-1:0] w_tmr;
    logic                  w_ovf;
    logic                  w_tmr_ovf_unused;
    logic                  w_thr_one;
    logic                  w_tmo_hit;
    logic                  w_in_accum;
    assign w_in_accum = r_state == ACCUM;
    assign w_eff_thr  = (threshold_i == '0) ? CntWidth'(1) : threshold_i;
    assign w_thr_one  = threshold_i <= CntWidth'(1);
    assign w_cnt_nxt  = (done_i && !(&w_cnt)) ? w_cnt + CntWidth'(1) : w_cnt;
    assign w_tmo_hit  = (timeout_i != '0) && (w_tmr == timeout_i - TimerWidth'(1));
    dma_irq_sat_counter #(.Width(CntWidth)) u_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (ack_i),
        .i_inc (done_i),
        .o_val (w_cnt),
        .o_ovf (w_ovf)
    );
    // Timer only runs in ACCUM and restarts from zero on every entry into it.
    dma_irq_sat_counter #(.Width(TimerWidth)) u_tmr (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (ack_i || !w_in_accum),
        .i_inc (w_in_accum && !ack_i),
        .o_val (w_tmr),
        .o_ovf (w_tmr_ovf_unused)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else if (ack_i || r_state == IDLE) begin
            r_state <= !done_i ? IDLE : w_thr_one ? FIRE : ACCUM;
        end else if (w_in_accum && (w_cnt_nxt >= w_eff_thr || w_tmo_hit)) begin
            r_state <= FIRE;
        end
    end
    assign irq_o      = (r_state == FIRE) && enable_i;
    assign pending_o  = w_cnt;
    assign overflow_o = w_ovf;
endmodule
